// File: rtl/aib_rx_pkg.sv
// Shared types and default constants for the AIB receive word aligner.
package aib_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_VERIFY,
        ST_LOCKED
    } align_state_e;

    localparam logic [7:0] DEFAULT_SYNC_WORD  = 8'hB8;
    localparam int         DEFAULT_VERIFY_CNT = 3;

endpackage

// File: rtl/aib_rx_sync_fifo.sv
// Single-clock output FIFO with extra-bit pointers, flush and a sticky overflow flag.
// Depth must be a power of two and at least 2.
module aib_rx_sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [Width-1:0] i_wr_data,
    input  logic             i_ready,
    output logic [Width-1:0] o_rd_data,
    output logic             o_valid,
    output logic             o_overflow
);

    localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign pop   = !empty && i_ready;
    // A pop frees the slot at the head, so a full FIFO still takes a same-cycle write.
    assign push  = i_wr_en && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + (AddrW + 1)'(push);
        rd_ptr_d   = rd_ptr_q + (AddrW + 1)'(pop);
        overflow_d = overflow_q || (i_wr_en && full && !pop);
        if (i_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= i_wr_data;
        end
    end

    assign o_valid    = !empty;
    assign o_rd_data  = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
    assign o_overflow = overflow_q;

endmodule

// File: rtl/aib_rx_word_aligner.sv
// Per-lane DDR deserialiser that finds the word boundary from a training pattern on
// lane 0, then pushes one multi-lane entry per word into the output FIFO.
module aib_rx_word_aligner
    import aib_rx_pkg::*;
#(
    parameter int                  NumIo     = 4,
    parameter int                  WordBits  = 8,
    parameter logic [WordBits-1:0] SyncWord  = WordBits'(DEFAULT_SYNC_WORD),
    parameter int                  VerifyCnt = DEFAULT_VERIFY_CNT,
    parameter int                  FifoDepth = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               c_align_en,
    input  logic                               c_realign,
    input  logic [NumIo-1:0]                   i_rx_data0,
    input  logic [NumIo-1:0]                   i_rx_data1,
    output logic [NumIo-1:0][WordBits-1:0]     o_word,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic                               o_locked,
    output logic                               o_overflow
);

    localparam int HalfWord = WordBits / 2;
    localparam int PhW      = (HalfWord > 1) ? $clog2(HalfWord) : 1;
    localparam int CntW     = (VerifyCnt > 1) ? $clog2(VerifyCnt + 1) : 1;
    localparam int FifoW    = NumIo * WordBits;

    align_state_e                  state_q, state_d;
    logic [NumIo-1:0][WordBits:0]  hist_q, hist_d;
    logic                          offset_q, offset_d;
    logic [PhW-1:0]                phase_q, phase_d;
    logic [CntW-1:0]               match_q, match_d;
    logic [CntW-1:0]               match_inc;
    logic [NumIo-1:0][WordBits-1:0] lane_word;
    logic                          match_off0;
    logic                          match_off1;
    logic                          lane0_match;
    logic                          boundary;
    logic                          wr_en;
    logic                          flush;
    logic [FifoW-1:0]              fifo_wr_data;
    logic [FifoW-1:0]              fifo_rd_data;

    // History keeps one spare older bit so the word can be taken at either bit offset.
    always_comb begin
        hist_d    = hist_q;
        lane_word = '0;
        for (int i = 0; i < NumIo; i++) begin
            hist_d[i]    = {hist_q[i][WordBits-2:0], i_rx_data0[i], i_rx_data1[i]};
            lane_word[i] = offset_q ? hist_q[i][WordBits:1] : hist_q[i][WordBits-1:0];
        end
    end

    assign match_off0  = (hist_q[0][WordBits-1:0] == SyncWord);
    assign match_off1  = (hist_q[0][WordBits:1] == SyncWord);
    assign lane0_match = (lane_word[0] == SyncWord);
    assign boundary    = (phase_q == PhW'(HalfWord - 1));
    assign match_inc   = match_q + CntW'(1);
    assign flush       = c_realign && (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        match_d  = match_q;
        phase_d  = boundary ? '0 : phase_q + PhW'(1);
        wr_en    = 1'b0;
        if (!c_align_en) begin
            state_d = ST_IDLE;
        end else if (flush) begin
            state_d = ST_SEARCH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (match_off0 || match_off1) begin
                        offset_d = !match_off0;
                        phase_d  = '0;
                        match_d  = CntW'(1);
                        state_d  = (VerifyCnt <= 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (boundary) begin
                        if (lane0_match) begin
                            match_d = match_inc;
                            if (match_inc == CntW'(VerifyCnt)) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            state_d = ST_SEARCH;
                        end
                    end
                end
                ST_LOCKED: begin
                    wr_en = boundary;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            hist_q   <= '0;
            offset_q <= 1'b0;
            phase_q  <= '0;
            match_q  <= '0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            offset_q <= offset_d;
            phase_q  <= phase_d;
            match_q  <= match_d;
        end
    end

    assign fifo_wr_data = lane_word;

    aib_rx_sync_fifo #(
        .Width (FifoW),
        .Depth (FifoDepth)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_flush    (flush),
        .i_wr_en    (wr_en),
        .i_wr_data  (fifo_wr_data),
        .i_ready    (i_ready),
        .o_rd_data  (fifo_rd_data),
        .o_valid    (o_valid),
        .o_overflow (o_overflow)
    );

    assign o_word   = fifo_rd_data;
    assign o_locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_aib_rx_word_aligner.sv
// Bench for aib_rx_word_aligner: per-lane bit streams are built as word lists and the
// expected lock/output timing and contents are derived from stream bit positions.
module tb_aib_rx_word_aligner;

    localparam logic [7:0] SYNC = 8'hB8;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            c_align_en = 1'b0;
    logic            c_realign = 1'b0;
    logic [1:0]      i_rx_data0 = '0;
    logic [1:0]      i_rx_data1 = '0;
    logic [1:0][7:0] o_word;
    logic            o_valid;
    logic            i_ready = 1'b0;
    logic            o_locked;
    logic            o_overflow;

    int          checks = 0;
    int          failures = 0;
    bit          lane0_q[$];
    bit          lane1_q[$];
    int          pushed;
    int          step;
    int          first_lock_step;
    int          first_valid_step;
    logic [15:0] rx_q[$];

    aib_rx_word_aligner #(
        .NumIo     (2),
        .WordBits  (8),
        .SyncWord  (8'hB8),
        .VerifyCnt (3),
        .FifoDepth (4)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .c_align_en (c_align_en),
        .c_realign  (c_realign),
        .i_rx_data0 (i_rx_data0),
        .i_rx_data1 (i_rx_data1),
        .o_word     (o_word),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_locked   (o_locked),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One call per cycle: drive two bits per lane at the negedge, log any pop that the
    // coming posedge will perform, and note the first lock/valid observation.
    task automatic applyStimulus(input int n);
        logic [1:0] b0, b1;
        for (int s = 0; s < n; s++) begin
            b0 = '0;
            b1 = '0;
            for (int k = 0; k < 2; k++) begin
                b0[1-k] = (lane0_q.size() > 0) ? lane0_q.pop_front() : 1'b0;
                b1[1-k] = (lane1_q.size() > 0) ? lane1_q.pop_front() : 1'b0;
            end
            i_rx_data0 = {b1[1], b0[1]};
            i_rx_data1 = {b1[0], b0[0]};
            if (o_valid && i_ready) rx_q.push_back(o_word);
            if (o_locked && first_lock_step < 0) first_lock_step = step;
            if (o_valid && first_valid_step < 0) first_valid_step = step;
            @(negedge i_clk);
            step++;
        end
    endtask

    task automatic doReset();
        i_rst_n    = 1'b0;
        c_align_en = 1'b0;
        c_realign  = 1'b0;
        i_ready    = 1'b0;
        i_rx_data0 = '0;
        i_rx_data1 = '0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic startStream();
        lane0_q.delete();
        lane1_q.delete();
        rx_q.delete();
        pushed           = 0;
        step             = 0;
        first_lock_step  = -1;
        first_valid_step = -1;
    endtask

    task automatic pushWord(input logic [7:0] w0, input logic [7:0] w1, output int last_pos);
        for (int b = 7; b >= 0; b--) begin
            lane0_q.push_back(w0[b]);
            lane1_q.push_back(w1[b]);
        end
        pushed  += 8;
        last_pos = pushed - 1;
    endtask

    task automatic pushPad(input int n);
        for (int k = 0; k < n; k++) begin
            lane0_q.push_back(1'b0);
            lane1_q.push_back(1'($urandom_range(0, 1)));
        end
        pushed += n;
    endtask

    task automatic pushSync(input int n, output int last_pos);
        last_pos = -1;
        for (int k = 0; k < n; k++) pushWord(SYNC, 8'($urandom), last_pos);
    endtask

    task automatic runUntilRx(input int want, input int budget);
        for (int k = 0; k < budget && rx_q.size() < want; k++) applyStimulus(1);
    endtask

    task automatic drainFifo(input int budget);
        i_ready = 1'b1;
        for (int k = 0; k < budget && o_valid; k++) applyStimulus(1);
    endtask

    function automatic logic [15:0] rxAt(input int k);
        if (k < rx_q.size()) return rx_q[k];
        return 'x;
    endfunction

    // A bit at stream position p is driven in step p/2; a word completed there is
    // acted on at the following edge and seen one step after that.
    initial begin
        int          pos, lock_pos, p0, p1;
        logic [7:0]  a1, b1, c0, c1;
        logic [7:0]  w0 [6];
        logic [7:0]  w1 [6];

        @(negedge i_clk);
        $display("[TB] reset values");
        doReset();
        checkOutput("rst_valid", o_valid, 0);
        checkOutput("rst_locked", o_locked, 0);
        checkOutput("rst_overflow", o_overflow, 0);
        checkOutput("rst_word", o_word, 0);

        $display("[TB] lock at offset 0");
        startStream();
        i_ready = 1'b1;
        c_align_en = 1'b1;
        pushPad(4);
        pushSync(3, lock_pos);
        a1 = 8'($urandom);
        b1 = 8'($urandom);
        pushWord(8'h5A, a1, p0);
        pushWord(8'h3C, b1, p1);
        pushPad(16);
        runUntilRx(2, 80);
        checkOutput("a_lock_step", first_lock_step, lock_pos / 2 + 2);
        checkOutput("a_valid_step", first_valid_step, p0 / 2 + 2);
        checkOutput("a_word0", rxAt(0), {a1, 8'h5A});
        checkOutput("a_word1", rxAt(1), {b1, 8'h3C});
        checkOutput("a_overflow", o_overflow, 0);

        $display("[TB] lock at offset 1");
        doReset();
        startStream();
        i_ready = 1'b1;
        c_align_en = 1'b1;
        pushPad(5);
        pushSync(3, lock_pos);
        pushWord(8'h5A, a1, p0);
        pushWord(8'h3C, b1, p1);
        pushPad(16);
        runUntilRx(2, 80);
        checkOutput("b_lock_step", first_lock_step, lock_pos / 2 + 2);
        checkOutput("b_valid_step", first_valid_step, p0 / 2 + 2);
        checkOutput("b_word0", rxAt(0), {a1, 8'h5A});
        checkOutput("b_word1", rxAt(1), {b1, 8'h3C});

        $display("[TB] verify failure then relock");
        doReset();
        startStream();
        i_ready = 1'b1;
        c_align_en = 1'b1;
        pushPad(4);
        pushSync(2, pos);
        pushWord(8'h77, 8'($urandom), pos);
        pushWord(8'hFF, 8'($urandom), pos);
        pushWord(8'hFF, 8'($urandom), pos);
        pushSync(3, lock_pos);
        c0 = 8'($urandom);
        c1 = 8'($urandom);
        pushWord(c0, c1, p0);
        pushPad(16);
        runUntilRx(1, 120);
        checkOutput("c_lock_step", first_lock_step, lock_pos / 2 + 2);
        checkOutput("c_word0", rxAt(0), {c1, c0});

        $display("[TB] overflow with stalled consumer");
        doReset();
        startStream();
        i_ready = 1'b0;
        c_align_en = 1'b1;
        pushPad(4);
        pushSync(3, lock_pos);
        for (int k = 0; k < 6; k++) begin
            w0[k] = 8'($urandom);
            w1[k] = 8'($urandom);
            pushWord(w0[k], w1[k], pos);
        end
        pushPad(8);
        applyStimulus(pos / 2 + 3);
        checkOutput("d_overflow_set", o_overflow, 1);
        checkOutput("d_held_word", o_word, {w1[0], w0[0]});
        c_align_en = 1'b0;
        applyStimulus(2);
        checkOutput("d_unlocked", o_locked, 0);
        drainFifo(20);
        checkOutput("d_drain_count", rx_q.size(), 4);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("d_word%0d", k), rxAt(k), {w1[k], w0[k]});
        checkOutput("d_overflow_sticky", o_overflow, 1);

        $display("[TB] pop and write on full FIFO");
        doReset();
        startStream();
        i_ready = 1'b0;
        c_align_en = 1'b1;
        pushPad(4);
        pushSync(3, lock_pos);
        p0 = 0;
        for (int k = 0; k < 6; k++) begin
            w0[k] = 8'($urandom);
            w1[k] = 8'($urandom);
            pushWord(w0[k], w1[k], pos);
            if (k == 4) p0 = pos;
        end
        pushPad(8);
        applyStimulus(p0 / 2 + 1);
        i_ready = 1'b1;
        applyStimulus(1);
        i_ready = 1'b0;
        c_align_en = 1'b0;
        applyStimulus(3);
        checkOutput("e_overflow_clear", o_overflow, 0);
        drainFifo(20);
        checkOutput("e_total_count", rx_q.size(), 5);
        for (int k = 0; k < 5; k++)
            checkOutput($sformatf("e_word%0d", k), rxAt(k), {w1[k], w0[k]});

        $display("[TB] reset while locked");
        doReset();
        startStream();
        i_ready = 1'b0;
        c_align_en = 1'b1;
        pushPad(4);
        pushSync(3, lock_pos);
        pushWord(8'($urandom), 8'($urandom), pos);
        pushWord(8'($urandom), 8'($urandom), pos);
        pushPad(8);
        applyStimulus(pos / 2 + 3);
        checkOutput("f_locked_before", o_locked, 1);
        checkOutput("f_valid_before", o_valid, 1);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        checkOutput("f_valid_after", o_valid, 0);
        checkOutput("f_locked_after", o_locked, 0);
        checkOutput("f_word_after", o_word, 0);
        startStream();
        i_ready = 1'b1;
        pushPad(4);
        pushSync(3, lock_pos);
        c0 = 8'($urandom);
        c1 = 8'($urandom);
        pushWord(c0, c1, p0);
        pushPad(16);
        runUntilRx(1, 80);
        checkOutput("f_relock_step", first_lock_step, lock_pos / 2 + 2);
        checkOutput("f_word0", rxAt(0), {c1, c0});

        $display("[TB] realign flushes and clears overflow");
        doReset();
        startStream();
        i_ready = 1'b0;
        c_align_en = 1'b1;
        pushPad(4);
        pushSync(3, lock_pos);
        for (int k = 0; k < 6; k++) pushWord(8'($urandom), 8'($urandom), pos);
        pushPad(8);
        applyStimulus(pos / 2 + 3);
        checkOutput("g_overflow_set", o_overflow, 1);
        c_realign = 1'b1;
        applyStimulus(1);
        c_realign = 1'b0;
        checkOutput("g_valid", o_valid, 0);
        checkOutput("g_overflow", o_overflow, 0);
        checkOutput("g_locked", o_locked, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aib_rx_word_aligner.md
AIB_RX_WORD_ALIGNER -- requirements
Module: aib_rx_word_aligner

Interface
REQ-001 SHALL have parameter NumIo, default 4: number of RX lanes consumed from the IO block.
REQ-002 SHALL have parameter WordBits, default 8: output word width; must be even and at least 4.
REQ-003 SHALL have parameter SyncWord, default 8'hB8: training pattern expected on lane 0.
REQ-004 SHALL have parameter VerifyCnt, default 3: number of consecutive sync words required for lock.
REQ-005 SHALL have parameter FifoDepth, default 4: output FIFO entries; must be a power of 2.
REQ-006 SHALL have port i_clk  in  1  clock; this is the block's only clock.
REQ-007 SHALL have port i_rst_n  in  1  reset; it is synchronous and active-low.
REQ-008 SHALL have port c_align_en  in  1  enables the alignment state machine.
REQ-009 SHALL have port c_realign  in  1  one-cycle pulse that forces the state machine back to SEARCH.
REQ-010 SHALL have port i_rx_data0  in  1 x [NumIo]  earlier DDR bit per lane per cycle.
REQ-011 SHALL have port i_rx_data1  in  1 x [NumIo]  later DDR bit per lane per cycle.
REQ-012 SHALL have port o_word  out  WordBits x [NumIo]  aligned word per lane, taken from the FIFO head.
REQ-013 SHALL have port o_valid / i_ready  out / in  1  output handshake.
REQ-014 SHALL have port o_locked  out  1  high while in LOCKED.
REQ-015 SHALL have port o_overflow  out  1  sticky flag for a dropped word.

Function
REQ-016 Each cycle, each lane SHALL shift in data0 then data1 into a history register of WordBits+1 bits; the first-received bit becomes the word MSB.
REQ-017 The state machine SHALL have states IDLE, SEARCH, VERIFY and LOCKED.
REQ-018 When c_align_en=0, the state SHALL go to IDLE from any state; IDLE->SEARCH when c_align_en=1.
REQ-019 In SEARCH, each cycle lane 0 SHALL be compared against SyncWord at bit offset 0 (newest WordBits bits) and offset 1 (shifted one bit older).
REQ-020 On a match, the block SHALL latch the offset (offset 0 takes priority if both match), clear the phase counter and enter VERIFY.
REQ-021 The phase counter SHALL count modulo WordBits/2; a word boundary occurs when the counter equals WordBits/2-1.
REQ-022 In VERIFY, at each boundary a match on lane 0 SHALL increment the match count and a mismatch SHALL return the state to SEARCH.
REQ-023 VERIFY SHALL go to LOCKED when the match count reaches VerifyCnt; the initial SEARCH match counts as 1.
REQ-024 In LOCKED, at each boundary all NumIo lane words SHALL be written into the FIFO as one entry using the latched offset, with no content filtering.
REQ-025 A c_realign pulse SHALL take any non-IDLE state to SEARCH, flush the FIFO and clear o_overflow.
REQ-026 The entry for a boundary in cycle t SHALL be written at the end of cycle t; o_valid SHALL rise in cycle t+1 if the FIFO was empty.
REQ-027 A pop SHALL occur iff o_valid && i_ready; o_word SHALL hold stable while o_valid=1 and i_ready=0.
REQ-028 A write to a full FIFO without a same-cycle pop SHALL drop the entry and set o_overflow until reset or realign.
REQ-029 A simultaneous pop and write when the FIFO is full SHALL accept the write; a simultaneous pop and write when empty is not a bypass.
REQ-030 Leaving LOCKED SHALL stop writes while the FIFO keeps draining.
REQ-031 FIFO pointers SHALL wrap modulo FifoDepth, using an extra bit to distinguish full from empty.

Reset
REQ-032 With i_rst_n=0 sampled at an edge: state SHALL be IDLE, history, phase and match count SHALL be 0, the FIFO SHALL be empty, and o_valid, o_locked, o_overflow and o_word SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered words; no output is asserted in the cycle after reset release.

Structure
REQ-034 Package aib_rx_pkg SHALL hold the state enum and the default SyncWord and VerifyCnt constants.
REQ-035 The FIFO SHALL be sub-module aib_rx_sync_fifo, parameterised by width (NumIo*WordBits) and depth.

Verification
REQ-036 Setup NumIo=2, WordBits=8, SyncWord=B8, VerifyCnt=3; lane 0 sends B8 x3 at offset 0, then 5A, 3C -> o_locked rises; words 5A, 3C are output in order.
REQ-037 Same stream delayed by 1 bit -> lock with offset 1; output is identical to REQ-036.
REQ-038 B8, B8, 77 -> returns to SEARCH at the 77 boundary; o_locked stays 0.
REQ-039 Locked, i_ready=0 for 6 words -> 4 words held in the FIFO, 2 dropped, o_overflow=1; the 4 held words then drain in order.
REQ-040 Full FIFO with pop and write in the same cycle -> occupancy stays 4; o_overflow stays 0.
REQ-041 i_rst_n=0 for one cycle while locked with 2 words queued -> o_valid=0 and o_locked=0 on the next cycle; the state machine restarts from IDLE.
